instr_sequencer: RTL and testbench

Top-level instruction sequencer for the 16-bit bus microcontroller. It fetches one instruction word and holds it in the instruction register (IR). It decodes opcode IR[15:12] and dispatches the instruction to exactly one execution FSM (ALU, MOV or LDI) through a start/done handshake. Only one execution FSM owns the shared G0-G3/P0 bus at a time. The sequencer then advances the PC and fetches the next word.

---
 rtl/instr_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/dispatch sequencer for the 16-bit bus microcontroller.
// Latency: a NOP spans 4 cycles from mem_ready to the next mem_rd; a dispatched op spans 5+N.
// Backpressure: FETCH holds until mem_ready; WAIT holds until done or TIMEOUT. Optional: SINGLE_STEP_EN.
module instr_sequencer #(
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [15:0]      mem_data,
    input  logic             mem_ready,
    input  logic             alu_done,
    input  logic             mov_done,
    input  logic             ldi_done,
    output logic             mem_rd,
    output logic             pc_out_en,
    output logic             pc_inc,
    output logic [15:0]      ir,
    output logic             start_alu,
    output logic             start_mov,
    output logic             start_ldi,
    output logic             halted,
    output logic             illegal_err,
    output logic             timeout_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_DISPATCH = 3'd3,
        S_WAIT     = 3'd4,
        S_ADVANCE  = 3'd5,
        S_HALT     = 3'd6
`ifdef SINGLE_STEP_EN
        , S_PAUSE  = 3'd7
`endif
    } state_t;

    // Which execution unit owns the bus for the current instruction.
    typedef enum logic [1:0] {
        U_NONE = 2'd0,
        U_ALU  = 2'd1,
        U_MOV  = 2'd2,
        U_LDI  = 2'd3
    } unit_t;

    // Last timer value in WAIT; reaching it without done ends the instruction.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t           state_q;
    unit_t            unit_q;
    logic [7:0]       timer_q;
    logic [15:0]      ir_q;
    logic             mem_rd_q, pc_out_en_q, pc_inc_q;
    logic             start_alu_q, start_mov_q, start_ldi_q;
    logic             halted_q, illegal_err_q, timeout_err_q;
    logic [CNT_W-1:0] instr_count_q;
`ifdef SINGLE_STEP_EN
    logic             step_q;
`endif

    logic [3:0] opc;
    logic       op_alu, op_mov, op_ldi, op_nop, op_halt;
    logic       done_sel;

    // Opcode classes; 1000 is HALT, the rest of the 1xxx space goes to the ALU.
    always_comb begin
        opc     = ir_q[15:12];
        op_nop  = (opc == 4'b0000);
        op_mov  = (opc == 4'b0001);
        op_ldi  = (opc == 4'b0010);
        op_halt = (opc == 4'b1000);
        op_alu  = opc[3] && !op_halt;
    end

    // Only the dispatched unit's done is honoured; foreign dones are dropped here.
    always_comb begin
        done_sel = 1'b0;
        case (unit_q)
            U_ALU:   done_sel = alu_done;
            U_MOV:   done_sel = mov_done;
            U_LDI:   done_sel = ldi_done;
            default: done_sel = 1'b0;
        endcase
    end

    // Sequencer FSM; strobes are registered with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            unit_q        <= U_NONE;
            timer_q       <= 8'd0;
            ir_q          <= 16'd0;
            mem_rd_q      <= 1'b0;
            pc_out_en_q   <= 1'b0;
            pc_inc_q      <= 1'b0;
            start_alu_q   <= 1'b0;
            start_mov_q   <= 1'b0;
            start_ldi_q   <= 1'b0;
            halted_q      <= 1'b0;
            illegal_err_q <= 1'b0;
            timeout_err_q <= 1'b0;
            instr_count_q <= '0;
`ifdef SINGLE_STEP_EN
            step_q        <= 1'b0;
`endif
        end else begin
            mem_rd_q    <= 1'b0;
            pc_out_en_q <= 1'b0;
            pc_inc_q    <= 1'b0;
            start_alu_q <= 1'b0;
            start_mov_q <= 1'b0;
            start_ldi_q <= 1'b0;
`ifdef SINGLE_STEP_EN
            step_q      <= step;
`endif
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q     <= S_FETCH;
                        mem_rd_q    <= 1'b1;
                        pc_out_en_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= mem_data;
                        state_q <= S_DECODE;
                    end else begin
                        mem_rd_q    <= 1'b1;
                        pc_out_en_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    timer_q <= 8'd0;
                    if (op_alu || op_mov || op_ldi) begin
                        state_q     <= S_DISPATCH;
                        start_alu_q <= op_alu;
                        start_mov_q <= op_mov;
                        start_ldi_q <= op_ldi;
                        unit_q      <= op_alu ? U_ALU : (op_mov ? U_MOV : U_LDI);
                    end else if (op_halt) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        // Reserved opcodes retire as NOPs but leave a sticky flag.
                        if (!op_nop) begin
                            illegal_err_q <= 1'b1;
                        end
                        state_q  <= S_ADVANCE;
                        pc_inc_q <= 1'b1;
                    end
                end
                S_DISPATCH: begin
                    state_q <= S_WAIT;
                    timer_q <= timer_q + 8'd1;
                end
                S_WAIT: begin
                    timer_q <= timer_q + 8'd1;
                    if (done_sel) begin
                        state_q  <= S_ADVANCE;
                        pc_inc_q <= 1'b1;
                        unit_q   <= U_NONE;
                    end else if (timer_q == TMO_LAST) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= S_ADVANCE;
                        pc_inc_q      <= 1'b1;
                        unit_q        <= U_NONE;
                    end
                end
                S_ADVANCE: begin
                    instr_count_q <= instr_count_q + CNT_W'(1);
`ifdef SINGLE_STEP_EN
                    state_q <= S_PAUSE;
`else
                    if (run) begin
                        state_q     <= S_FETCH;
                        mem_rd_q    <= 1'b1;
                        pc_out_en_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
`endif
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
`ifdef SINGLE_STEP_EN
                S_PAUSE: begin
                    if (!run) begin
                        state_q <= S_IDLE;
                    end else if (step && !step_q) begin
                        state_q     <= S_FETCH;
                        mem_rd_q    <= 1'b1;
                        pc_out_en_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd      = mem_rd_q;
    assign pc_out_en   = pc_out_en_q;
    assign pc_inc      = pc_inc_q;
    assign ir          = ir_q;
    assign start_alu   = start_alu_q;
    assign start_mov   = start_mov_q;
    assign start_ldi   = start_ldi_q;
    assign halted      = halted_q;
    assign illegal_err = illegal_err_q;
    assign timeout_err = timeout_err_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed and random instructions against a cycle-count model.
// Outputs are sampled and inputs driven on the falling clock edge.
// The retired-instruction counter is narrowed so that wrap-around is reached quickly.
module tb_instr_sequencer;

    localparam int TMO = 32;
    localparam int CW  = 4;

    localparam int C_NOP  = 0;
    localparam int C_MOV  = 1;
    localparam int C_LDI  = 2;
    localparam int C_ALU  = 3;
    localparam int C_HALT = 4;
    localparam int C_ILL  = 5;

    logic          clk = 1'b0;
    logic          rst, run, mem_ready, alu_done, mov_done, ldi_done;
    logic [15:0]   mem_data;
    logic          mem_rd, pc_out_en, pc_inc, start_alu, start_mov, start_ldi;
    logic          halted, illegal_err, timeout_err;
    logic [15:0]   ir;
    logic [CW-1:0] instr_count;

    instr_sequencer #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .alu_done    (alu_done),
        .mov_done    (mov_done),
        .ldi_done    (ldi_done),
        .mem_rd      (mem_rd),
        .pc_out_en   (pc_out_en),
        .pc_inc      (pc_inc),
        .ir          (ir),
        .start_alu   (start_alu),
        .start_mov   (start_mov),
        .start_ldi   (start_ldi),
        .halted      (halted),
        .illegal_err (illegal_err),
        .timeout_err (timeout_err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: opcode class table, sticky flags, counter, IR contents.
    int          opclass [16];
    logic        ill_m, tmo_m;
    int          cnt_m;
    logic [15:0] ir_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk_all(input string ph, input logic mrd, input logic pci, input logic sa,
                           input logic sm, input logic sl, input logic h, input logic ie,
                           input logic te, input logic [15:0] irx, input int c);
        chk({ph, " mem_rd"},      32'(mem_rd),      32'(mrd));
        chk({ph, " pc_out_en"},   32'(pc_out_en),   32'(mrd));
        chk({ph, " pc_inc"},      32'(pc_inc),      32'(pci));
        chk({ph, " start_alu"},   32'(start_alu),   32'(sa));
        chk({ph, " start_mov"},   32'(start_mov),   32'(sm));
        chk({ph, " start_ldi"},   32'(start_ldi),   32'(sl));
        chk({ph, " halted"},      32'(halted),      32'(h));
        chk({ph, " illegal_err"}, 32'(illegal_err), 32'(ie));
        chk({ph, " timeout_err"}, 32'(timeout_err), 32'(te));
        chk({ph, " ir"},          32'(ir),          32'(irx));
        if (c >= 0) begin
            chk({ph, " instr_count"}, 32'(instr_count), 32'(c));
        end
    endtask

    task automatic model_reset;
        ill_m = 1'b0;
        tmo_m = 1'b0;
        cnt_m = 0;
        ir_m  = 16'h0000;
    endtask

    task automatic idle_check(input string ph, input int n);
        for (int i = 0; i < n; i++) begin
            chk_all(ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill_m, tmo_m, ir_m, cnt_m);
            tick;
        end
    endtask

    // From IDLE: raise run; the fetch request appears on the next cycle.
    task automatic go_fetch;
        run = 1'b1;
        tick;
    endtask

    // One instruction, entered on a FETCH cycle. ndone: cycles from start to the
    // unit's done (-1 = never). Cycle t=0 is the mem_ready cycle; expectations
    // come from the cycle budget: decode at 1, start at 2, retire after done or
    // after TMO-1 WAIT cycles.
    task automatic do_instr(input string ph, input logic [15:0] w, input int mwait,
                            input int ndone, input logic runv, input int foreign_t,
                            input logic noise, input int rst_at);
        int   cls, pci, last, cexp;
        logic disp, ok, hlt, s_a, s_m, s_l;
        cls  = opclass[w[15:12]];
        disp = (cls == C_MOV) || (cls == C_LDI) || (cls == C_ALU);
        hlt  = (cls == C_HALT);
        ok   = (ndone >= 1) && (ndone <= TMO - 1);
        pci  = disp ? (ok ? 3 + ndone : 2 + TMO) : 2;
        last = hlt ? 12 : pci + 1;
        s_a  = disp && (cls == C_ALU);
        s_m  = disp && (cls == C_MOV);
        s_l  = disp && (cls == C_LDI);
        run  = runv;
        for (int i = 0; i <= mwait; i++) begin
            chk_all({ph, " fetch"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill_m, tmo_m, ir_m, cnt_m);
            mem_ready = (i == mwait);
            mem_data  = (i == mwait) ? w : 16'($urandom);
            tick;
        end
        for (int t = 1; t <= last; t++) begin
            mem_ready = 1'b0;
            mem_data  = 16'($urandom);
            if (hlt || t < pci) cexp = cnt_m;
            else if (t > pci)   cexp = (cnt_m + 1) % (1 << CW);
            else                cexp = -1;
            chk_all($sformatf("%s t%0d", ph, t),
                    !hlt && (t == last) && runv,
                    !hlt && (t == pci),
                    s_a && (t == 2), s_m && (t == 2), s_l && (t == 2),
                    hlt && (t >= 2),
                    ill_m || ((cls == C_ILL) && (t >= 2)),
                    tmo_m || (disp && !ok && (t >= pci)),
                    w, cexp);
            if (t == rst_at) begin
                rst       = 1'b1;
                run       = 1'b0;
                alu_done  = 1'b0;
                mov_done  = 1'b0;
                ldi_done  = 1'b0;
                model_reset();
                #1;
                chk_all({ph, " async_rst"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
                tick;
                rst = 1'b0;
                return;
            end
            alu_done = s_a ? (t == 2 + ndone) : ((noise && 1'($urandom_range(0, 1))) || (t == foreign_t));
            mov_done = s_m ? (t == 2 + ndone) : ((noise && 1'($urandom_range(0, 1))) || (t == foreign_t));
            ldi_done = s_l ? (t == 2 + ndone) : ((noise && 1'($urandom_range(0, 1))) || (t == foreign_t));
            if (hlt) run = 1'($urandom_range(0, 1));
            if (t < last) tick;
        end
        alu_done = 1'b0;
        mov_done = 1'b0;
        ldi_done = 1'b0;
        ill_m = ill_m || (cls == C_ILL);
        tmo_m = tmo_m || (disp && !ok);
        if (!hlt) cnt_m = (cnt_m + 1) % (1 << CW);
        ir_m = w;
    endtask

    initial begin
        logic [15:0] w;
        int          nd, r;
        logic        rv;
        for (int i = 0; i < 16; i++) opclass[i] = C_ILL;
        opclass[0] = C_NOP;
        opclass[1] = C_MOV;
        opclass[2] = C_LDI;
        opclass[8] = C_HALT;
        for (int i = 9; i < 16; i++) opclass[i] = C_ALU;

        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; mem_data = 16'h0000;
        alu_done = 1'b0; mov_done = 1'b0; ldi_done = 1'b0;
        model_reset();
        tick;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
        rst = 1'b0;
        idle_check("idle", 10);

        go_fetch();
        do_instr("alu",      16'h9083, 2, 8,       1'b1, -1, 1'b0, -1);
        do_instr("mov_fgn",  16'h1042, 0, 5,       1'b1,  4, 1'b0, -1);
        do_instr("illegal",  16'h3000, 1, 0,       1'b1, -1, 1'b1, -1);
        do_instr("nop",      16'h0000, 0, 0,       1'b1, -1, 1'b1, -1);
        do_instr("ldi_tmo",  16'h2005, 0, -1,      1'b1, -1, 1'b0, -1);
        do_instr("ldi_last", 16'h2005, 0, TMO - 1, 1'b1, -1, 1'b1, -1);
        do_instr("alu_late", 16'hA123, 1, TMO,     1'b1, -1, 1'b1, -1);
        do_instr("mov_stop", 16'h1777, 0, 1,       1'b0, -1, 1'b0, -1);
        idle_check("idle2", 3);
        go_fetch();

        for (int k = 0; k < 40; k++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'b1000) w[15:12] = 4'b0000;
            r = int'($urandom_range(0, 9));
            if (r == 0)      nd = -1;
            else if (r < 3)  nd = int'($urandom_range(TMO - 2, TMO + 1));
            else             nd = int'($urandom_range(1, 10));
            rv = ($urandom_range(0, 7) != 0);
            do_instr($sformatf("rnd%0d", k), w, int'($urandom_range(0, 3)), nd, rv, -1, 1'b1, -1);
            if (!rv) begin
                idle_check("rnd_idle", 2);
                go_fetch();
            end
        end

        do_instr("rst_wait", 16'h1042, 0, 10, 1'b1, -1, 1'b0, 5);
        idle_check("post_rst", 3);
        go_fetch();
        do_instr("nop2", 16'h0ABC, 0, 0, 1'b1, -1, 1'b0, -1);
        do_instr("halt", 16'h8000, 1, 0, 1'b1, -1, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
